// File: rtl/lcd_hex_driver.sv
// HD44780 16x2 LCD driver, 8-bit write-only: power-up wait, init commands, then
// continuously rewrites line 1 columns 0-7 with a per-frame snapshot of Value in hex.
module lcd_hex_driver #(
    parameter int unsigned E_CYC     = 12,
    parameter int unsigned CMD_CYC   = 2000,
    parameter int unsigned CLR_CYC   = 82000,
    parameter int unsigned PWRUP_CYC = 750000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Value,
    output logic        LCD_E,
    output logic        LCD_RS,
    output logic        LCD_RW,
    output logic [7:0]  LCD_DB,
    output logic        Ready,
    output logic        FrameDone
);

    localparam int unsigned MaxA   = (PWRUP_CYC > CLR_CYC) ? PWRUP_CYC : CLR_CYC;
    localparam int unsigned MaxB   = (CMD_CYC > E_CYC) ? CMD_CYC : E_CYC;
    localparam int unsigned MaxCyc = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);

    typedef enum logic [1:0] {StPwrup, StInit, StAddr, StChar} state_e;
    typedef enum logic [1:0] {PhSetup, PhStrobe, PhWait} phase_e;

    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [2:0]        idx_q, idx_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [CntW-1:0]   wait_last;
    logic [31:0]       snap_q, snap_d;
    logic              e_q, e_d;
    logic              rs_q, rs_d;
    logic [7:0]        db_q, db_d;
    logic              ready_q, ready_d;
    logic              frame_q, frame_d;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        logic [7:0] cmd;
        case (i)
            2'd0:    cmd = 8'h38;
            2'd1:    cmd = 8'h0C;
            2'd2:    cmd = 8'h01;
            default: cmd = 8'h06;
        endcase
        return cmd;
    endfunction

    // The clear command (third init byte) needs the long settle time.
    assign wait_last = (state_q == StInit && idx_q == 3'd2) ? CntW'(CLR_CYC - 1)
                                                           : CntW'(CMD_CYC - 1);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CntW'(1);
        snap_d  = snap_q;
        rs_d    = rs_q;
        db_d    = db_q;
        ready_d = ready_q;
        frame_d = 1'b0;
        e_d     = 1'b0;

        if (state_q == StAddr && phase_q == PhSetup) begin
            snap_d = Value;
        end

        unique case (state_q)
            StPwrup: begin
                if (cnt_q == CntW'(PWRUP_CYC)) begin
                    state_d = StInit;
                    phase_d = PhSetup;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                end
            end
            default: begin
                unique case (phase_q)
                    PhSetup: begin
                        phase_d = PhStrobe;
                        cnt_d   = '0;
                    end
                    PhStrobe: begin
                        if (cnt_q == CntW'(E_CYC - 1)) begin
                            phase_d = PhWait;
                            cnt_d   = '0;
                        end
                    end
                    PhWait: begin
                        if (cnt_q == wait_last) begin
                            phase_d = PhSetup;
                            cnt_d   = '0;
                            unique case (state_q)
                                StInit: begin
                                    if (idx_q == 3'd3) begin
                                        state_d = StAddr;
                                        idx_d   = 3'd0;
                                    end else begin
                                        idx_d = idx_q + 3'd1;
                                    end
                                end
                                StAddr: begin
                                    state_d = StChar;
                                    idx_d   = 3'd0;
                                end
                                StChar: begin
                                    if (idx_q == 3'd7) begin
                                        state_d = StAddr;
                                        frame_d = 1'b1;
                                    end else begin
                                        idx_d = idx_q + 3'd1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    default: ;
                endcase
            end
        endcase

        // Bus is loaded on entry to SETUP and then held through STROBE and WAIT.
        if (state_d != StPwrup && phase_d == PhSetup) begin
            unique case (state_d)
                StInit: begin
                    rs_d = 1'b0;
                    db_d = init_cmd(idx_d[1:0]);
                end
                StAddr: begin
                    rs_d = 1'b0;
                    db_d = 8'h80;
                end
                StChar: begin
                    rs_d = 1'b1;
                    db_d = hex_ascii(snap_q[{~idx_d, 2'b00} +: 4]);
                end
                default: ;
            endcase
        end

        e_d = (state_d != StPwrup) && (phase_d == PhStrobe);
        if (state_d == StAddr) begin
            ready_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StPwrup;
            phase_q <= PhSetup;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
            snap_q  <= 32'd0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            db_q    <= 8'h00;
            ready_q <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            db_q    <= db_d;
            ready_q <= ready_d;
            frame_q <= frame_d;
        end
    end

    assign LCD_E     = e_q;
    assign LCD_RS    = rs_q;
    assign LCD_RW    = 1'b0;
    assign LCD_DB    = db_q;
    assign Ready     = ready_q;
    assign FrameDone = frame_q;

endmodule

// File: tb/tb_lcd_hex_driver.sv
// Scoreboard bench for lcd_hex_driver: stimulus pushes expected bytes and strobe cycles,
// a negedge monitor pops and compares on every LCD_E rise and checks per-cycle flags.
module tb_lcd_hex_driver;

    localparam int E_CYC     = 2;
    localparam int CMD_CYC   = 4;
    localparam int CLR_CYC   = 10;
    localparam int PWRUP_CYC = 20;

    localparam int NormByte   = 1 + E_CYC + CMD_CYC;
    localparam int ClrByte    = 1 + E_CYC + CLR_CYC;
    localparam int ReadyAt    = PWRUP_CYC + 3 * NormByte + ClrByte;
    localparam int FrameLen   = 9 * NormByte;
    localparam int FirstDone  = ReadyAt + FrameLen;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] Value = 32'd0;
    logic        LCD_E, LCD_RS, LCD_RW, Ready, FrameDone;
    logic [7:0]  LCD_DB;

    lcd_hex_driver #(
        .E_CYC    (E_CYC),
        .CMD_CYC  (CMD_CYC),
        .CLR_CYC  (CLR_CYC),
        .PWRUP_CYC(PWRUP_CYC)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Value    (Value),
        .LCD_E    (LCD_E),
        .LCD_RS   (LCD_RS),
        .LCD_RW   (LCD_RW),
        .LCD_DB   (LCD_DB),
        .Ready    (Ready),
        .FrameDone(FrameDone)
    );

    always #5 CLK = ~CLK;

    // Cycle k = the clock period following the k-th rising edge with RST high.
    int cyc = -1;
    always @(posedge CLK) cyc <= RST ? cyc + 1 : -1;

    typedef struct {
        logic       rs;
        logic [7:0] db;
        int         rise;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   t_next;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [31:0] v, input int k);
        string digits = "0123456789ABCDEF";
        int    nib;
        nib = int'((v >> (28 - 4 * k)) & 32'hF);
        return digits[nib];
    endfunction

    // Reference timing: each byte is SETUP + E strobe + settle time.
    task automatic push_byte(input logic rs, input logic [7:0] db);
        exp_q.push_back('{rs, db, t_next + 1});
        t_next += 1 + E_CYC + ((!rs && db == 8'h01) ? CLR_CYC : CMD_CYC);
    endtask

    task automatic at_cycle(input int n);
        while (cyc < n) @(negedge CLK);
    endtask

    task automatic do_init();
        t_next = PWRUP_CYC;
        push_byte(1'b0, 8'h38);
        push_byte(1'b0, 8'h0C);
        push_byte(1'b0, 8'h01);
        push_byte(1'b0, 8'h06);
    endtask

    task automatic start_frame(input logic [31:0] v);
        at_cycle(t_next);
        Value = v;
        push_byte(1'b0, 8'h80);
        for (int k = 0; k < 8; k++) push_byte(1'b1, hex_char(v, k));
    endtask

    task automatic run_frame(input logic [31:0] v, input logic [31:0] mid1,
                             input logic [31:0] mid2);
        int setup;
        setup = t_next;
        start_frame(v);
        at_cycle(setup + 26);
        Value = mid1;
        at_cycle(setup + 40);
        Value = mid2;
    endtask

    // Monitor
    logic       prev_e = 1'b0;
    logic       prev_rs = 1'b0;
    logic [7:0] prev_db = 8'h00;
    bit         have_fall = 1'b0;
    bit         prev_exp_clr = 1'b0;
    int         rise_cyc = 0;
    int         fall_cyc = 0;
    exp_t       got;

    always @(negedge CLK) begin
        if (!RST) begin
            check("reset outputs", int'({LCD_E, LCD_RS, LCD_RW, LCD_DB, Ready, FrameDone}), 0);
            prev_e    = 1'b0;
            prev_rs   = 1'b0;
            prev_db   = 8'h00;
            have_fall = 1'b0;
        end else if (cyc >= 0) begin
            check("LCD_RW", int'(LCD_RW), 0);
            check("Ready", int'(Ready), int'(cyc >= ReadyAt));
            check("FrameDone", int'(FrameDone),
                  int'(cyc >= FirstDone && (cyc - ReadyAt) % FrameLen == 0));
            if (cyc < PWRUP_CYC) check("pwrup bus", int'({LCD_E, LCD_RS, LCD_DB}), 0);
            if (LCD_E && !prev_e) begin
                check("bus stable at E rise", int'({LCD_RS, LCD_DB}), int'({prev_rs, prev_db}));
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected byte: got rs=%0d db=0x%0h, expected none (cycle %0d)",
                             LCD_RS, LCD_DB, cyc);
                end else begin
                    got = exp_q.pop_front();
                    check("byte rs/db", int'({LCD_RS, LCD_DB}), int'({got.rs, got.db}));
                    check("E rise cycle", cyc, got.rise);
                    if (have_fall) check("wait length", cyc - 1 - fall_cyc,
                                         prev_exp_clr ? CLR_CYC : CMD_CYC);
                    prev_exp_clr = !got.rs && got.db == 8'h01;
                end
                rise_cyc = cyc;
            end
            if (!LCD_E && prev_e) begin
                check("E width", cyc - rise_cyc, E_CYC);
                fall_cyc  = cyc;
                have_fall = 1'b1;
            end
            prev_e  = LCD_E;
            prev_rs = LCD_RS;
            prev_db = LCD_DB;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

    logic [31:0] vals [7];
    int          setup;

    initial begin
        vals[0] = 32'hDEADBEEF;
        vals[1] = 32'h09AF0123;
        vals[2] = 32'h11111111;
        vals[3] = 32'h22222222;
        for (int i = 4; i < 7; i++) vals[i] = $urandom;

        #1 RST = 1'b0;
        repeat (3) @(negedge CLK);
        Value = $urandom;
        do_init();
        RST = 1'b1;

        at_cycle(30);
        Value = $urandom;
        for (int f = 0; f < 7; f++) begin
            run_frame(vals[f], (f < 6) ? vals[f + 1] : $urandom, $urandom);
        end

        // Reset while char 3 of this frame is strobing.
        setup = t_next;
        start_frame($urandom);
        at_cycle(setup + 4 * NormByte + 1);
        #1;
        check("E high before reset", int'(LCD_E), 1);
        RST = 1'b0;
        #1;
        check("E after async reset", int'(LCD_E), 0);
        check("Ready after async reset", int'(Ready), 0);
        exp_q.delete();
        repeat (3) @(negedge CLK);
        do_init();
        RST = 1'b1;

        run_frame($urandom, $urandom, $urandom);
        run_frame($urandom, $urandom, $urandom);
        at_cycle(t_next);
        check("scoreboard drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
